// File: rtl/rs_syndrome_calc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package  : rs_pkg                                                  |
// | Purpose  : GF(2^8) constants, symbol type, alpha-power helper and  |
// |            FSM state encoding for the RS syndrome calculator.      |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
package rs_pkg;

  localparam int         SYM_W   = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef logic [SYM_W-1:0] SYM_T;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  // alpha^(e mod 255) by repeated doubling; only evaluated at elaboration
  function automatic SYM_T gf_alpha_pow(input int e);
    SYM_T v;
    int   k;
    v = SYM_T'(1);
    k = e % 255;
    if (k < 0) k = k + 255;
    for (int i = 0; i < k; i++) begin
      v = v[SYM_W-1] ? ((v << 1) ^ GF_POLY[SYM_W-1:0]) : (v << 1);
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rs_syndrome_calc_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Interface: rs_syndrome_calc_if                                     |
// | Purpose  : Symbol input and syndrome output handshakes.            |
// |            syn_zero exists only with RS_SYN_ZERO_FLAG_EN defined.  |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
interface rs_syndrome_calc_if #(
  parameter int SIZE   = 8,
  parameter int NROOTS = 16
);
  logic                   in_valid;
  logic                   in_ready;
  logic [SIZE-1:0]        in_sym;
  logic                   in_last;
  logic                   syn_valid;
  logic                   syn_ready;
  logic [NROOTS*SIZE-1:0] syn_out;
  logic                   len_err;
`ifdef RS_SYN_ZERO_FLAG_EN
  logic                   syn_zero;

  modport master (output in_valid, in_sym, in_last, syn_ready,
                  input  in_ready, syn_valid, syn_out, len_err, syn_zero);
  modport slave  (input  in_valid, in_sym, in_last, syn_ready,
                  output in_ready, syn_valid, syn_out, len_err, syn_zero);
`else
  modport master (output in_valid, in_sym, in_last, syn_ready,
                  input  in_ready, syn_valid, syn_out, len_err);
  modport slave  (input  in_valid, in_sym, in_last, syn_ready,
                  output in_ready, syn_valid, syn_out, len_err);
`endif
endinterface
`default_nettype wire

// File: rtl/rs_syndrome_calc_cell.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Modules  : gf_mul, rs_syn_cell                                     |
// | Purpose  : GF(2^8) multiplier and one Horner syndrome register.    |
// |            o_next port exists only with RS_SYN_ZERO_FLAG_EN.       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module gf_mul
  import rs_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_b,
  output logic [SIZE-1:0] o_p
);
  logic [SIZE-1:0] w_a;

  // shift-and-add product with modular reduction after each doubling
  always_comb begin
    o_p = '0;
    w_a = i_a;
    for (int i = 0; i < SIZE; i++) begin
      if (i_b[i]) o_p = o_p ^ w_a;
      w_a = w_a[SIZE-1] ? ((w_a << 1) ^ GF_POLY[SIZE-1:0]) : (w_a << 1);
    end
  end
endmodule

module rs_syn_cell
  import rs_pkg::*;
#(
  parameter int M        = 255,
  parameter int SIZE     = 8,
  parameter int ROOT_EXP = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_load,
  input  logic            i_first,
  input  logic [SIZE-1:0] i_sym,
`ifdef RS_SYN_ZERO_FLAG_EN
  output logic [SIZE-1:0] o_next,
`endif
  output logic [SIZE-1:0] o_syn
);
  localparam SYM_T C_ROOT = gf_alpha_pow(ROOT_EXP % M);

  logic [SIZE-1:0] r_syn;
  logic [SIZE-1:0] w_prod;
  logic [SIZE-1:0] w_next;

  gf_mul #(.SIZE(SIZE)) u_mul (
    .i_a (r_syn),
    .i_b (C_ROOT),
    .o_p (w_prod)
  );

  // first symbol seeds the register so a stale result never leaks in
  assign w_next = i_first ? i_sym : (w_prod ^ i_sym);

  // syndrome register advances once per accepted symbol
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_syn <= '0;
    else if (i_load) r_syn <= w_next;
  end

  assign o_syn = r_syn;
`ifdef RS_SYN_ZERO_FLAG_EN
  assign o_next = w_next;
`endif
endmodule
`default_nettype wire

// File: rtl/rs_syndrome_calc.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : rs_syndrome_calc                                        |
// | Purpose  : Streaming RS(GF(2^8)) syndrome generator, one Horner    |
// |            cell per root; FSM, length count and handshakes here.   |
// | Options  : RS_SYN_ZERO_FLAG_EN adds syn_zero (all S_j == 0).       |
// | Revision : 1.0 - initial release                                   |
// +--------------------------------------------------------------------+
module rs_syndrome_calc
  import rs_pkg::*;
#(
  parameter int m      = 255,
  parameter int SIZE   = $clog2(m),
  parameter int NROOTS = 16,
  parameter int FCR    = 0,
  parameter int N      = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  rs_syndrome_calc_if.slave    bus
);
  localparam int CNT_W = $clog2(N + 1);

  state_t                 r_state;
  logic [CNT_W-1:0]       r_count;
  logic                   r_syn_valid;
  logic                   r_len_err;
  logic                   w_in_ready;
  logic                   w_xfer;
  logic                   w_full;
  logic                   w_done;
  logic                   w_first;
  logic [NROOTS*SIZE-1:0] w_syn_flat;

  // ready is forced low while reset is asserted
  assign w_in_ready = rst_n & (r_state != HOLD);
  assign w_xfer     = bus.in_valid & w_in_ready;
  assign w_full     = (r_count == CNT_W'(N - 1));
  assign w_done     = w_xfer & (bus.in_last | w_full);
  assign w_first    = (r_state == IDLE);

`ifdef RS_SYN_ZERO_FLAG_EN
  logic [NROOTS*SIZE-1:0] w_next_flat;
  logic                   r_syn_zero;
`endif

  for (genvar j = 0; j < NROOTS; j++) begin : g_cell
    rs_syn_cell #(
      .M        (m),
      .SIZE     (SIZE),
      .ROOT_EXP (FCR + j)
    ) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_xfer),
      .i_first (w_first),
      .i_sym   (bus.in_sym),
`ifdef RS_SYN_ZERO_FLAG_EN
      .o_next  (w_next_flat[j*SIZE +: SIZE]),
`endif
      .o_syn   (w_syn_flat[j*SIZE +: SIZE])
    );
  end

  // codeword FSM: accumulate until in_last or N symbols, then hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_syn_valid <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACCUM: begin
          if (w_done) begin
            r_state     <= HOLD;
            r_count     <= '0;
            r_syn_valid <= 1'b1;
            // without in_last the only way here is hitting N
            r_len_err   <= ~bus.in_last;
          end else if (w_xfer) begin
            r_state <= ACCUM;
            r_count <= r_count + CNT_W'(1);
          end
        end
        HOLD: begin
          if (bus.syn_ready) begin
            r_state     <= IDLE;
            r_syn_valid <= 1'b0;
            r_len_err   <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef RS_SYN_ZERO_FLAG_EN
  // zero flag tracks the syndrome registers' next contents
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_syn_zero <= 1'b0;
    else if (w_xfer) r_syn_zero <= (w_next_flat == '0);
  end
  assign bus.syn_zero = r_syn_zero;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.syn_valid = r_syn_valid;
  assign bus.syn_out   = w_syn_flat;
  assign bus.len_err   = r_len_err;
endmodule
`default_nettype wire
